// File: rtl/cfg_bank_mux.sv
// Config-request fan-out to NUM_BANKS register banks with merged ack, multi-hit detection and timeout.
// Optional sideband-to-CR SAI conversion at acceptance: define CFG_BANK_MUX_SAI_CONV_EN.
module cfg_bank_mux #(
    parameter int DATA_W      = 32,
    parameter int NUM_BANKS   = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int TIMEOUT_W   = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [3:0]                  req_opcode,
    input  logic [47:0]                 req_addr,
    input  logic [DATA_W/8-1:0]         req_be,
    input  logic [DATA_W-1:0]           req_data,
    input  logic [7:0]                  req_sai,
    input  logic [7:0]                  req_fid,
    input  logic [2:0]                  req_bar,

    output logic [NUM_BANKS-1:0]        bank_req_valid,
    output logic [3:0]                  bank_req_opcode,
    output logic [47:0]                 bank_req_addr,
    output logic [DATA_W/8-1:0]         bank_req_be,
    output logic [DATA_W-1:0]           bank_req_data,
    output logic [7:0]                  bank_req_sai,
    output logic [7:0]                  bank_req_fid,
    output logic [2:0]                  bank_req_bar,

    input  logic [NUM_BANKS-1:0]        bank_read_valid,
    input  logic [NUM_BANKS-1:0]        bank_read_miss,
    input  logic [NUM_BANKS-1:0]        bank_write_valid,
    input  logic [NUM_BANKS-1:0]        bank_write_miss,
    input  logic [NUM_BANKS-1:0]        bank_sai_ok,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,

    output logic                        ack_valid,
    output logic                        ack_read_valid,
    output logic                        ack_read_miss,
    output logic                        ack_write_valid,
    output logic                        ack_write_miss,
    output logic                        ack_sai_ok,
    output logic [DATA_W-1:0]           ack_data,
    output logic                        ack_multi_hit,
    output logic                        ack_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        TIMEOUT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t                 state_q;
    state_t                 state_d;

    logic [NUM_BANKS-1:0]   done_q;
    logic [NUM_BANKS-1:0]   hit_q;
    logic [DATA_W-1:0]      data_q;
    logic                   sai_ok_q;
    logic [TIMEOUT_W-1:0]   cnt_q;

    logic                   accept;
    logic                   collecting;
    logic                   is_write;
    logic [NUM_BANKS-1:0]   ack_sel;
    logic [NUM_BANKS-1:0]   hit_sel;
    logic [NUM_BANKS-1:0]   new_done;
    logic [NUM_BANKS-1:0]   new_hit;
    logic [DATA_W-1:0]      new_data;
    logic                   new_sai_ok;
    logic                   all_done;
    logic                   timeout_fire;
    logic [NUM_BANKS-1:0]   final_hit;
    logic                   final_any;
    logic                   final_multi;
    logic [7:0]             sai_cr;

`ifdef CFG_BANK_MUX_SAI_CONV_EN
    function automatic logic [7:0] sai_conv(input logic [7:0] sai);
        logic [7:0] res;
        if (sai[0]) begin
            res = (sai[7:4] != 4'd0) ? 8'h3F : {5'b0, sai[3:1]};
        end else begin
            res = ((sai[7:1] > 7'd7) && (sai[7:1] < 7'd63)) ? {2'b00, sai[6:1]} : 8'h3F;
        end
        return res;
    endfunction

    assign sai_cr = sai_conv(req_sai);
`else
    assign sai_cr = req_sai;
`endif

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign collecting = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign is_write   = bank_req_opcode[0];

    // Per-bank done/hit for this cycle; banks already done are masked so repeat acks are ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ack_sel    = is_write ? (bank_write_valid | bank_write_miss)
                              : (bank_read_valid  | bank_read_miss);
        hit_sel    = is_write ? (bank_write_valid & ~bank_write_miss)
                              : (bank_read_valid  & ~bank_read_miss);
        new_done   = collecting ? (~done_q & ack_sel) : '0;
        new_hit    = new_done & hit_sel;
        new_data   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (new_hit[i]) begin
                new_data = new_data | bank_rdata[i*DATA_W +: DATA_W];
            end
        end
        new_sai_ok = |(new_hit & bank_sai_ok);
    end

    assign all_done     = &(done_q | new_done);
    // Completion takes priority over a timeout landing in the same cycle.
    assign timeout_fire = (TIMEOUT_CYC != 0) && (state_q == ST_WAIT) &&
                          (cnt_q == TO_LAST) && !all_done;

    assign final_hit   = timeout_fire ? '0 : (hit_q | new_hit);
    assign final_any   = |final_hit;
    assign final_multi = (final_hit & (final_hit - 1'b1)) != '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so all flops update together.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = all_done ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (all_done || timeout_fire) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        bank_req_valid = (state_q == ST_ISSUE) ? '1 : '0;
        ack_valid      = (state_q == ST_RESP);
    end

    // Registered request fields, held stable from acceptance until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain registers, not a memory array, so they are all cleared on reset.
        if (!rst_n) begin
            bank_req_opcode <= '0;
            bank_req_addr   <= '0;
            bank_req_be     <= '0;
            bank_req_data   <= '0;
            bank_req_sai    <= '0;
            bank_req_fid    <= '0;
            bank_req_bar    <= '0;
        end else if (accept) begin
            bank_req_opcode <= req_opcode;
            bank_req_addr   <= req_addr;
            bank_req_be     <= req_be;
            bank_req_data   <= req_data;
            bank_req_sai    <= sai_cr;
            bank_req_fid    <= req_fid;
            bank_req_bar    <= req_bar;
        end
    end

    // Ack collection: done/hit masks, OR-accumulated hit data and SAI, WAIT cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= '0;
            hit_q    <= '0;
            data_q   <= '0;
            sai_ok_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            done_q   <= '0;
            hit_q    <= '0;
            data_q   <= '0;
            sai_ok_q <= 1'b0;
            cnt_q    <= '0;
        end else if (collecting) begin
            done_q   <= done_q | new_done;
            hit_q    <= hit_q | new_hit;
            data_q   <= data_q | new_data;
            sai_ok_q <= sai_ok_q | new_sai_ok;
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Merged ack, captured on entry to RESP and held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_read_valid  <= 1'b0;
            ack_read_miss   <= 1'b0;
            ack_write_valid <= 1'b0;
            ack_write_miss  <= 1'b0;
            ack_sai_ok      <= 1'b0;
            ack_data        <= '0;
            ack_multi_hit   <= 1'b0;
            ack_timeout     <= 1'b0;
        end else if (collecting && (state_d == ST_RESP)) begin
            ack_read_valid  <= !is_write &&  final_any;
            ack_read_miss   <= !is_write && !final_any;
            ack_write_valid <=  is_write &&  final_any;
            ack_write_miss  <=  is_write && !final_any;
            ack_sai_ok      <= final_any && (sai_ok_q | new_sai_ok);
            ack_data        <= (!is_write && final_any) ? (data_q | new_data) : '0;
            ack_multi_hit   <= final_multi;
            ack_timeout     <= timeout_fire;
        end
    end

endmodule

// File: tb/tb_cfg_bank_mux.sv
// Directed self-checking bench for cfg_bank_mux (4 banks, 32-bit data, TIMEOUT_CYC=8).
module tb_cfg_bank_mux;

    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_opcode = '0;
    logic [47:0]   req_addr = '0;
    logic [DW/8-1:0] req_be = '0;
    logic [DW-1:0] req_data = '0;
    logic [7:0]    req_sai = '0;
    logic [7:0]    req_fid = '0;
    logic [2:0]    req_bar = '0;
    logic [NB-1:0] bank_req_valid;
    logic [3:0]    bank_req_opcode;
    logic [47:0]   bank_req_addr;
    logic [DW/8-1:0] bank_req_be;
    logic [DW-1:0] bank_req_data;
    logic [7:0]    bank_req_sai;
    logic [7:0]    bank_req_fid;
    logic [2:0]    bank_req_bar;
    logic [NB-1:0] bank_read_valid = '0;
    logic [NB-1:0] bank_read_miss = '0;
    logic [NB-1:0] bank_write_valid = '0;
    logic [NB-1:0] bank_write_miss = '0;
    logic [NB-1:0] bank_sai_ok = '0;
    logic [NB*DW-1:0] bank_rdata = '0;
    logic          ack_valid;
    logic          ack_read_valid;
    logic          ack_read_miss;
    logic          ack_write_valid;
    logic          ack_write_miss;
    logic          ack_sai_ok;
    logic [DW-1:0] ack_data;
    logic          ack_multi_hit;
    logic          ack_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cfg_bank_mux #(.DATA_W(DW), .NUM_BANKS(NB), .TIMEOUT_CYC(8), .TIMEOUT_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_be(req_be), .req_data(req_data), .req_sai(req_sai),
        .req_fid(req_fid), .req_bar(req_bar),
        .bank_req_valid(bank_req_valid), .bank_req_opcode(bank_req_opcode),
        .bank_req_addr(bank_req_addr), .bank_req_be(bank_req_be), .bank_req_data(bank_req_data),
        .bank_req_sai(bank_req_sai), .bank_req_fid(bank_req_fid), .bank_req_bar(bank_req_bar),
        .bank_read_valid(bank_read_valid), .bank_read_miss(bank_read_miss),
        .bank_write_valid(bank_write_valid), .bank_write_miss(bank_write_miss),
        .bank_sai_ok(bank_sai_ok), .bank_rdata(bank_rdata),
        .ack_valid(ack_valid), .ack_read_valid(ack_read_valid), .ack_read_miss(ack_read_miss),
        .ack_write_valid(ack_write_valid), .ack_write_miss(ack_write_miss),
        .ack_sai_ok(ack_sai_ok), .ack_data(ack_data), .ack_multi_hit(ack_multi_hit),
        .ack_timeout(ack_timeout)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Advance to just after the next rising edge; all driving and sampling happens there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acks();
        bank_read_valid  = '0;
        bank_read_miss   = '0;
        bank_write_valid = '0;
        bank_write_miss  = '0;
        bank_sai_ok      = '0;
        bank_rdata       = '0;
    endtask

    // Offer a request for one cycle; returns in the ISSUE cycle.
    task automatic send(input logic [3:0] op, input logic [47:0] addr, input logic [7:0] sai);
        req_opcode = op;
        req_addr   = addr;
        req_sai    = sai;
        req_be     = '1;
        req_data   = 32'h1234_5678;
        req_fid    = 8'h11;
        req_bar    = 3'd2;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    logic [7:0] sai_in  [4] = '{8'h05, 8'h31, 8'h20, 8'h02};
`ifdef CFG_BANK_MUX_SAI_CONV_EN
    logic [7:0] sai_exp [4] = '{8'h02, 8'h3F, 8'h10, 8'h3F};
`else
    logic [7:0] sai_exp [4] = '{8'h05, 8'h31, 8'h20, 8'h02};
`endif

    logic [NB-1:0] stagger [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b1000, 4'b0100};

    initial begin
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_bank_req_valid", bank_req_valid, 0);
        check("rst_ack_valid", ack_valid, 0);
        check("rst_ack_data", ack_data, 0);
        check("rst_bank_req_addr", bank_req_addr, 0);
        #10 rst_n = 1'b1;
        step();

        // CRRD: bank 2 hits in ISSUE, others miss
        send(4'd6, 48'h10, 8'h00);
        check("t1_bank_req_valid", bank_req_valid, 4'hF);
        check("t1_bank_req_addr", bank_req_addr, 48'h10);
        check("t1_req_ready", req_ready, 0);
        check("t1_ack_valid_issue", ack_valid, 0);
        bank_read_valid = 4'b0100;
        bank_read_miss  = 4'b1011;
        bank_sai_ok     = 4'b0100;
        bank_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
        step();
        clear_acks();
        check("t1_ack_valid", ack_valid, 1);
        check("t1_ack_read_valid", ack_read_valid, 1);
        check("t1_ack_read_miss", ack_read_miss, 0);
        check("t1_ack_data", ack_data, 32'hDEAD_BEEF);
        check("t1_multi_hit", ack_multi_hit, 0);
        check("t1_sai_ok", ack_sai_ok, 1);
        check("t1_timeout", ack_timeout, 0);
        step();
        check("t1_ack_valid_drop", ack_valid, 0);
        check("t1_req_ready_back", req_ready, 1);
        check("t1_ack_data_hold", ack_data, 32'hDEAD_BEEF);

        // CRWR: write misses staggered over cycles 1,3,5,4
        send(4'd7, 48'h20, 8'h00);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t2_bank_req_valid_c%0d", c + 1), bank_req_valid, (c == 0) ? 4'hF : 4'h0);
            check($sformatf("t2_ack_valid_c%0d", c + 1), ack_valid, 0);
            bank_write_miss = stagger[c];
            step();
            clear_acks();
        end
        check("t2_ack_valid", ack_valid, 1);
        check("t2_ack_write_miss", ack_write_miss, 1);
        check("t2_ack_write_valid", ack_write_valid, 0);
        check("t2_ack_read_valid", ack_read_valid, 0);
        check("t2_ack_data", ack_data, 0);
        check("t2_bank_req_addr", bank_req_addr, 48'h20);
        step();

        // MRD: banks 0 and 1 hit; bank 2 misses then repeats a (ignored) hit
        send(4'd0, 48'h30, 8'h00);
        bank_read_valid = 4'b0011;
        bank_read_miss  = 4'b0100;
        bank_rdata[0 +: DW]    = 32'h0F;
        bank_rdata[DW +: DW]   = 32'hF0;
        step();
        clear_acks();
        check("t3_ack_valid_wait", ack_valid, 0);
        bank_read_miss  = 4'b1000;
        bank_read_valid = 4'b0100;
        bank_sai_ok     = 4'b0100;
        bank_rdata[2*DW +: DW] = 32'hFFFF_0000;
        step();
        clear_acks();
        check("t3_ack_valid", ack_valid, 1);
        check("t3_ack_read_valid", ack_read_valid, 1);
        check("t3_ack_data", ack_data, 32'hFF);
        check("t3_multi_hit", ack_multi_hit, 1);
        check("t3_sai_ok", ack_sai_ok, 0);
        step();

        // CFGRD: bank 3 silent -> timeout after 8 WAIT cycles, partial hits discarded
        send(4'd4, 48'h40, 8'h00);
        bank_read_valid = 4'b0111;
        bank_sai_ok     = 4'b0111;
        bank_rdata[0 +: DW] = 32'h1;
        step();
        clear_acks();
        for (int w = 0; w < 8; w++) begin
            check($sformatf("t4_ack_valid_wait%0d", w), ack_valid, 0);
            step();
        end
        check("t4_ack_valid", ack_valid, 1);
        check("t4_ack_timeout", ack_timeout, 1);
        check("t4_ack_read_miss", ack_read_miss, 1);
        check("t4_ack_read_valid", ack_read_valid, 0);
        check("t4_ack_data", ack_data, 0);
        check("t4_multi_hit", ack_multi_hit, 0);
        check("t4_sai_ok", ack_sai_ok, 0);
        step();
        bank_read_valid = 4'b1000;
        bank_rdata[3*DW +: DW] = 32'hAAAA_5555;
        step();
        clear_acks();
        check("t4_late_ack_valid", ack_valid, 0);
        check("t4_late_req_ready", req_ready, 1);
        check("t4_late_timeout_hold", ack_timeout, 1);
        send(4'd1, 48'h50, 8'h00);
        bank_write_valid = 4'b0010;
        bank_write_miss  = 4'b1101;
        bank_rdata[DW +: DW] = 32'h7777_7777;
        step();
        clear_acks();
        check("t4_next_ack_valid", ack_valid, 1);
        check("t4_next_write_valid", ack_write_valid, 1);
        check("t4_next_timeout", ack_timeout, 0);
        check("t4_next_data", ack_data, 0);
        step();

        // Reset asserted during WAIT
        send(4'd2, 48'h60, 8'h00);
        bank_read_miss = 4'b0001;
        step();
        clear_acks();
        check("t5_in_wait_ack_valid", ack_valid, 0);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_req_ready", req_ready, 1);
        check("t5_rst_bank_req_valid", bank_req_valid, 0);
        check("t5_rst_bank_req_addr", bank_req_addr, 0);
        check("t5_rst_ack_valid", ack_valid, 0);
        check("t5_rst_ack_write_valid", ack_write_valid, 0);
        #3 rst_n = 1'b1;
        step();
        bank_read_miss = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            step();
            clear_acks();
            check($sformatf("t5_no_ack_%0d", k), ack_valid, 0);
            check($sformatf("t5_ready_%0d", k), req_ready, 1);
        end

        // SAI encoding onto bank_req_sai
        for (int s = 0; s < 4; s++) begin
            send(4'd6, 48'h70, sai_in[s]);
            check($sformatf("t6_sai_%02h", sai_in[s]), bank_req_sai, sai_exp[s]);
            bank_read_miss = 4'hF;
            step();
            clear_acks();
            check($sformatf("t6_miss_%0d", s), ack_read_miss, 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
